spi_reg_ctrl: RTL

- Command/transaction controller behind the byte-level SPI slave.
- Frames the received byte stream into register-bank transactions:
  - Byte 0 is the command: bit7 = R/nW, bits[ADDR_W-1:0] = start address.
  - Following bytes are burst data, with the address auto-incrementing.
- Drives a simple single-cycle register bus.
- Preloads the slave's transmit byte for read bursts.

---
 rtl/spi_reg_ctrl_if.sv | 30 +++
 rtl/spi_reg_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl_if.sv
// Signal bundle between the SPI byte slave / register bank and spi_reg_ctrl.
// "master" is the controller's view; "slave" is the view of the surrounding logic.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              cs;
    logic              byte_valid;
    logic [7:0]        byte_rx;
    logic [7:0]        byte_tx;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr_en;
    logic [7:0]        reg_wr_data;
    logic              reg_rd_en;
    logic [7:0]        reg_rd_data;
    logic              busy;
    logic              frame_done;
    logic              frame_err;

    modport master (
        input  cs, byte_valid, byte_rx, reg_rd_data,
        output byte_tx, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en,
               busy, frame_done, frame_err
    );

    modport slave (
        output cs, byte_valid, byte_rx, reg_rd_data,
        input  byte_tx, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en,
               busy, frame_done, frame_err
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Frames the SPI byte stream into command + burst register transactions on a
// single-cycle register bus, and preloads the transmit byte for read bursts.
module spi_reg_ctrl #(
    parameter int         ADDR_W  = 7,
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] IDLE_TX = 8'h00
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    spi_reg_ctrl_if.master    bus
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_WR_DATA  = 3'd2;
    localparam logic [2:0] S_RD_FETCH = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_DATA  = 3'd5;
    localparam logic [2:0] S_OVF      = 3'd6;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_reg_addr;
    logic              r_wr_en;
    logic [7:0]        r_wr_data;
    logic              r_rd_en;
    logic [7:0]        r_byte_tx;
    logic              r_done;
    logic              r_err;

    logic [ADDR_W-1:0] w_addr_inc;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_last;
    logic              w_data_state;

    assign w_addr_inc   = r_addr + 1'b1;
    assign w_cnt_inc    = r_count + 1'b1;
    assign w_last       = (w_cnt_inc == CNT_W'(MAX_LEN));
    assign w_data_state = (r_state == S_WR_DATA) || (r_state == S_RD_DATA) ||
                          (r_state == S_RD_FETCH) || (r_state == S_RD_WAIT);

    // Frame FSM and all registered bus/status outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_reg_addr <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= 8'h00;
            r_rd_en    <= 1'b0;
            r_byte_tx  <= IDLE_TX;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            // Chip-select release wins over any byte arriving in the same cycle.
            if ((r_state != S_IDLE) && bus.cs) begin
                r_state   <= S_IDLE;
                r_byte_tx <= IDLE_TX;
                r_done    <= w_data_state && (r_count != '0);
                r_err     <= (r_state == S_OVF);
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!bus.cs) begin
                            r_state <= S_CMD;
                            r_count <= '0;
                        end
                    end
                    S_CMD: begin
                        if (bus.byte_valid) begin
                            r_addr <= bus.byte_rx[ADDR_W-1:0];
                            if (bus.byte_rx[7]) begin
                                // Strobe is launched here so it is high throughout RD_FETCH.
                                r_state    <= S_RD_FETCH;
                                r_rd_en    <= 1'b1;
                                r_reg_addr <= bus.byte_rx[ADDR_W-1:0];
                            end else begin
                                r_state <= S_WR_DATA;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (bus.byte_valid) begin
                            r_wr_en    <= 1'b1;
                            r_wr_data  <= bus.byte_rx;
                            r_reg_addr <= r_addr;
                            r_addr     <= w_addr_inc;
                            r_count    <= w_cnt_inc;
                            r_state    <= w_last ? S_OVF : S_WR_DATA;
                        end
                    end
                    S_RD_FETCH: begin
                        r_state <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        r_byte_tx <= bus.reg_rd_data;
                        r_state   <= S_RD_DATA;
                    end
                    S_RD_DATA: begin
                        if (bus.byte_valid) begin
                            r_count <= w_cnt_inc;
                            r_addr  <= w_addr_inc;
                            if (w_last) begin
                                r_state   <= S_OVF;
                                r_byte_tx <= IDLE_TX;
                            end else begin
                                r_state    <= S_RD_FETCH;
                                r_rd_en    <= 1'b1;
                                r_reg_addr <= w_addr_inc;
                            end
                        end
                    end
                    S_OVF: begin
                        r_byte_tx <= IDLE_TX;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_byte_tx <= IDLE_TX;
                    end
                endcase
            end
        end
    end

    assign bus.byte_tx     = r_byte_tx;
    assign bus.reg_addr    = r_reg_addr;
    assign bus.reg_wr_en   = r_wr_en;
    assign bus.reg_wr_data = r_wr_data;
    assign bus.reg_rd_en   = r_rd_en;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.frame_done  = r_done;
    assign bus.frame_err   = r_err;
endmodule
